// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
//   XLEN      : datapath width
//   AW        : register address width
//   NREG      : number of architectural registers (2**AW)
//   reg_idx_t : register index type
package regfile_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  typedef logic [AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requester at or after ptr, wrapping modulo N.
//   req   in  N   request vector
//   ptr   in  IW  index with highest priority this cycle (must be < N)
//   grant out N   one-hot grant, zero when no request
//   idx   out IW  encoded index of the granted requester
//   any   out 1   at least one request granted
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      // ptr < N and k < N, so a single subtraction implements the wrap.
      if (j >= N) begin
        j = j - N;
      end
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ
// writeback requesters, with a pending-write scoreboard for RAW hazards.
//   clk, reset   clock / asynchronous active-low reset
//   req_valid    per-requester write pending
//   req_rd       per-requester destination register (AW bits each)
//   req_data     per-requester write data (XLEN bits each)
//   req_ready    one-hot grant; a transfer happens on valid & ready
//   alloc_valid  mark alloc_rd as having a pending write
//   alloc_rd     register being allocated
//   rs1, rs2     source registers to hazard-check
//   rs1_busy     busy[rs1] from current state
//   rs2_busy     busy[rs2] from current state
//   rf_we        registered regfile write enable
//   rf_rd        registered regfile write address
//   rf_wdata     registered regfile write data
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = regfile_pkg::XLEN,
  parameter int unsigned AW   = regfile_pkg::AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_rd,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            accept;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // No grants are presented while reset is held.
  assign req_ready = reset ? grant : '0;
  assign accept    = reset & gnt_any;

  assign gnt_rd   = req_rd[32'(gnt_idx)*AW +: AW];
  assign gnt_data = req_data[32'(gnt_idx)*XLEN +: XLEN];

  always_comb begin
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;

    if (accept) begin
      ptr_d      = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      // Writes to x0 are consumed but never reach the regfile.
      rf_we_d    = (gnt_rd != '0);
      rf_rd_d    = gnt_rd;
      rf_wdata_d = gnt_data;
      busy_d[gnt_rd] = 1'b0;
    end

    // Applied after the clear so a same-register allocate wins.
    if (alloc_valid && (alloc_rd != '0)) begin
      busy_d[alloc_rd] = 1'b1;
    end

    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule
